// File: rtl/sequenciador_operacao.sv
// rtl/sequenciador_operacao.sv - X sweep initiator for the "operacao" polynomial evaluator.
// Optional handshake watchdog is built in when SEQ_TIMEOUT_EN is defined.
module sequenciador_operacao #(
  parameter int LARG_X  = 8,
  parameter int LARG_D  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicio,
  input  logic [LARG_X-1:0] x_ini,
  input  logic [LARG_X-1:0] x_fim,
  input  logic [LARG_X-1:0] passo,
  input  logic [LARG_D-1:0] A,
  input  logic [LARG_D-1:0] B,
  input  logic [LARG_D-1:0] C,
  output logic              op_inicio,
  output logic [LARG_X-1:0] op_X,
  output logic [LARG_D-1:0] op_A,
  output logic [LARG_D-1:0] op_B,
  output logic [LARG_D-1:0] op_C,
  input  logic              op_comecou,
  input  logic              op_pronto,
  input  logic [LARG_D-1:0] op_resultado,
  output logic [LARG_D-1:0] saida,
  output logic [LARG_X-1:0] saida_x,
  output logic              saida_valida,
  input  logic              saida_pega,
  output logic              ocupado,
  output logic              terminou,
  output logic [LARG_D-1:0] maior,
  output logic              erro
);

  typedef enum logic [2:0] {OCIOSO, DISPARA, AGUARDA, ENTREGA, PROXIMO, FIM} estado_t;

  estado_t           estado_q, estado_d;
  logic [LARG_X-1:0] x_atual_q, x_atual_d, x_fim_q, x_fim_d, passo_q, passo_d;
  logic [LARG_X-1:0] saida_x_q, saida_x_d;
  logic [LARG_D-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [LARG_D-1:0] saida_q, saida_d, maior_q, maior_d;
  logic [LARG_X:0]   nx;
  logic              passou;
  logic              estouro;

  // One extra bit so a step past the top of the X range ends the sweep instead of wrapping.
  assign nx     = {1'b0, x_atual_q} + {1'b0, passo_q};
  assign passou = nx > {1'b0, x_fim_q};

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cont_q, cont_d;
  logic          erro_q, erro_d;

  assign estouro = (cont_q == CW'(TIMEOUT - 1));
  assign erro    = erro_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cont_q <= '0;
      erro_q <= 1'b0;
    end else begin
      cont_q <= cont_d;
      erro_q <= erro_d;
    end
  end

  always_comb begin
    cont_d = '0;
    erro_d = erro_q;
    if ((estado_q == DISPARA || estado_q == AGUARDA) && estado_d == estado_q)
      cont_d = cont_q + 1'b1;
    if (estado_q == OCIOSO && inicio)
      erro_d = 1'b0;
    else if ((estado_q == DISPARA || estado_q == AGUARDA) && estado_d == FIM)
      erro_d = 1'b1;
  end
`else
  assign estouro = 1'b0;
  assign erro    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      x_atual_q <= '0;
      x_fim_q   <= '0;
      passo_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      saida_q   <= '0;
      saida_x_q <= '0;
      maior_q   <= '0;
    end else begin
      estado_q  <= estado_d;
      x_atual_q <= x_atual_d;
      x_fim_q   <= x_fim_d;
      passo_q   <= passo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      saida_q   <= saida_d;
      saida_x_q <= saida_x_d;
      maior_q   <= maior_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO:  if (inicio) estado_d = (x_ini > x_fim) ? FIM : DISPARA;
      DISPARA: if (op_comecou) estado_d = AGUARDA; else if (estouro) estado_d = FIM;
      AGUARDA: if (op_pronto) estado_d = ENTREGA; else if (estouro) estado_d = FIM;
      ENTREGA: if (saida_pega) estado_d = PROXIMO;
      // A stale pronto from the previous X must clear before the next request.
      PROXIMO: if (passou) estado_d = FIM; else if (!op_pronto) estado_d = DISPARA;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    x_atual_d = x_atual_q;
    x_fim_d   = x_fim_q;
    passo_d   = passo_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    saida_d   = saida_q;
    saida_x_d = saida_x_q;
    maior_d   = maior_q;
    case (estado_q)
      OCIOSO: if (inicio) begin
        x_fim_d = x_fim;
        passo_d = (passo == '0) ? LARG_X'(1) : passo;
        a_d     = A;
        b_d     = B;
        c_d     = C;
        maior_d = '0;
        if (x_ini <= x_fim) x_atual_d = x_ini;
      end
      AGUARDA: if (op_pronto) begin
        saida_d   = op_resultado;
        saida_x_d = x_atual_q;
        if (op_resultado > maior_q) maior_d = op_resultado;
      end
      PROXIMO: if (!passou && !op_pronto) x_atual_d = nx[LARG_X-1:0];
      default: ;
    endcase
  end

  always_comb begin
    op_inicio    = 1'b0;
    saida_valida = 1'b0;
    ocupado      = 1'b1;
    terminou     = 1'b0;
    case (estado_q)
      OCIOSO:           ocupado      = 1'b0;
      DISPARA, AGUARDA: op_inicio    = 1'b1;
      ENTREGA:          saida_valida = 1'b1;
      FIM:              terminou     = 1'b1;
      default: ;
    endcase
  end

  assign op_X    = x_atual_q;
  assign op_A    = a_q;
  assign op_B    = b_q;
  assign op_C    = c_q;
  assign saida   = saida_q;
  assign saida_x = saida_x_q;
  assign maior   = maior_q;

endmodule

// File: tb/tb_sequenciador_operacao.sv
// tb/tb_sequenciador_operacao.sv - randomized self-checking bench for sequenciador_operacao.
// Evaluator and consumer are modelled here; expected sweeps come from a plain arithmetic model.
module tb_sequenciador_operacao;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inicio = 1'b0;
  logic [7:0]  x_ini = '0, x_fim = '0, passo = '0;
  logic [15:0] A = '0, B = '0, C = '0;
  logic        op_inicio;
  logic [7:0]  op_X;
  logic [15:0] op_A, op_B, op_C;
  logic        op_comecou = 1'b0;
  logic        op_pronto = 1'b0;
  logic [15:0] op_resultado = '0;
  logic [15:0] saida;
  logic [7:0]  saida_x;
  logic        saida_valida;
  logic        saida_pega = 1'b1;
  logic        ocupado;
  logic        terminou;
  logic [15:0] maior;
  logic        erro;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  sequenciador_operacao #(.LARG_X(8), .LARG_D(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .inicio(inicio),
    .x_ini(x_ini), .x_fim(x_fim), .passo(passo),
    .A(A), .B(B), .C(C),
    .op_inicio(op_inicio), .op_X(op_X), .op_A(op_A), .op_B(op_B), .op_C(op_C),
    .op_comecou(op_comecou), .op_pronto(op_pronto), .op_resultado(op_resultado),
    .saida(saida), .saida_x(saida_x), .saida_valida(saida_valida), .saida_pega(saida_pega),
    .ocupado(ocupado), .terminou(terminou), .maior(maior), .erro(erro)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Evaluator stand-in: comecou one cycle after the request, pronto three cycles later.
  int ev_cnt = 0;
  bit no_comecou = 1'b0;
  always @(negedge clk) begin
    if (op_inicio) ev_cnt = ev_cnt + 1; else ev_cnt = 0;
    op_comecou   = !no_comecou && ev_cnt >= 2;
    op_pronto    = op_comecou && ev_cnt >= 5;
    op_resultado = op_A * op_X * op_X + op_B * op_X + op_C;
  end

  int pega_mode = 0;
  int blk = 0;
  always @(negedge clk) begin
    case (pega_mode)
      1: saida_pega = 1'($urandom_range(0, 1));
      2: if (saida_valida && blk < 10) begin saida_pega = 1'b0; blk++; end
         else saida_pega = 1'b1;
      default: saida_pega = 1'b1;
    endcase
  end

  int got_x[$];
  int got_r[$];
  int term_cnt, valid_cnt, opi_cnt, opi_in_valid, instab, first_opi, term_cyc;
  logic pv = 1'b0, pp = 1'b0;
  logic [15:0] ps = '0;
  logic [7:0]  px = '0;
  always @(negedge clk) begin
    #3;
    if (saida_valida && saida_pega) begin
      got_x.push_back(int'(saida_x));
      got_r.push_back(int'(saida));
    end
    if (terminou) begin
      if (term_cnt == 0) term_cyc = cyc;
      term_cnt++;
    end
    if (op_inicio) begin
      if (first_opi < 0) first_opi = cyc;
      opi_cnt++;
    end
    if (saida_valida) valid_cnt++;
    if (saida_valida && op_inicio) opi_in_valid++;
    if (saida_valida && pv && !pp && (saida !== ps || saida_x !== px)) instab++;
    pv = saida_valida; pp = saida_pega; ps = saida; px = saida_x;
  end

  task automatic clear_mon();
    got_x.delete(); got_r.delete();
    term_cnt = 0; valid_cnt = 0; opi_cnt = 0; opi_in_valid = 0; instab = 0;
    first_opi = -1; term_cyc = -1; blk = 0;
  endtask

  task automatic wait_term(input int budget, input bit inject, output int n);
    n = 0;
    while (n < budget) begin
      #4;
      if (term_cnt != 0) break;
      @(negedge clk);
      n++;
      inicio = inject && ocupado && !terminou && ($urandom_range(0, 7) == 0);
    end
    inicio = 1'b0;
  endtask

  task automatic run_sweep(input string nm, input int xi, input int xf, input int p,
                           input int a, input int b, input int c, input int mode, input bit inject);
    int ex_x[$];
    int ex_r[$];
    longint r;
    int mx, x, st, n;
    mx = 0;
    x = xi;
    while (xi <= xf && x <= xf) begin
      r = (longint'(a) * x * x + longint'(b) * x + longint'(c)) % 65536;
      ex_x.push_back(x);
      ex_r.push_back(int'(r));
      if (int'(r) > mx) mx = int'(r);
      x += (p == 0) ? 1 : p;
    end
    clear_mon();
    pega_mode = mode;
    @(negedge clk);
    x_ini = 8'(xi); x_fim = 8'(xf); passo = 8'(p);
    A = 16'(a); B = 16'(b); C = 16'(c);
    inicio = 1'b1;
    st = cyc;
    @(negedge clk);
    inicio = 1'b0;
    A = 16'($urandom); B = 16'($urandom); C = 16'($urandom);
    x_fim = 8'($urandom); passo = 8'($urandom);
    wait_term(3000, inject, n);
    check_val({nm, "_done"}, 64'(n < 3000), 1);
    repeat (2) @(negedge clk);
    #4;
    check_val({nm, "_count"}, got_x.size(), ex_x.size());
    for (int i = 0; i < ex_x.size(); i++) begin
      check_val($sformatf("%s_x%0d", nm, i), (i < got_x.size()) ? got_x[i] : -1, ex_x[i]);
      check_val($sformatf("%s_r%0d", nm, i), (i < got_r.size()) ? got_r[i] : -1, ex_r[i]);
    end
    check_val({nm, "_maior"}, maior, mx);
    check_val({nm, "_term"}, term_cnt, 1);
    check_val({nm, "_ocupado"}, ocupado, 0);
    check_val({nm, "_erro"}, erro, 0);
    check_val({nm, "_stable"}, instab, 0);
    if (ex_x.size() > 0) check_val({nm, "_lat"}, first_opi - st, 1);
    else begin
      check_val({nm, "_no_opi"}, opi_cnt, 0);
      check_val({nm, "_no_valid"}, valid_cnt, 0);
      check_val({nm, "_term_lat"}, term_cyc - st, 1);
    end
  endtask

  initial begin
    int xi, xf, n;
    clear_mon();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_ctl", {op_inicio, saida_valida, ocupado, terminou, erro}, 0);
    check_val("rst_op", {op_X, op_A, op_B, op_C}, 0);
    check_val("rst_res", {saida, saida_x, maior}, 0);
    @(negedge clk);
    reset = 1'b1;

    run_sweep("basic", 0, 3, 1, 1, 2, 5, 0, 0);
    run_sweep("empty", 5, 2, 1, 1, 2, 5, 0, 0);
    run_sweep("hold", 0, 3, 1, 1, 2, 5, 2, 0);
    check_val("hold_valid_cycles", valid_cnt, 14);
    check_val("hold_no_opi", opi_in_valid, 0);
    run_sweep("nowrap", 250, 255, 4, 3, 7, 11, 0, 0);
    run_sweep("passo0", 7, 9, 0, 2, 1, 9, 0, 0);
    run_sweep("single", 42, 42, 3, 100, 200, 300, 0, 0);

    clear_mon();
    @(negedge clk);
    x_ini = 8'd2; x_fim = 8'd3; passo = 8'd1; A = 16'd1; B = 16'd2; C = 16'd5;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("pre_rst_busy", {ocupado, op_inicio}, 2'b11);
    #1;
    reset = 1'b0;
    #1;
    check_val("mid_rst_ctl", {op_inicio, saida_valida, ocupado, terminou, erro}, 0);
    check_val("mid_rst_op", {op_X, op_A, op_B, op_C}, 0);
    check_val("mid_rst_res", {saida, saida_x, maior}, 0);
    @(negedge clk);
    reset = 1'b1;
    run_sweep("post_rst", 0, 3, 1, 1, 2, 5, 0, 0);

    for (int k = 0; k < 10; k++) begin
      xi = int'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) xf = (xi > 0) ? int'($urandom_range(0, xi - 1)) : 0;
      else xf = (xi + int'($urandom_range(0, 12)) > 255) ? 255 : xi + int'($urandom_range(0, 12));
      run_sweep($sformatf("rnd%0d", k), xi, xf, int'($urandom_range(0, 5)),
                int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)), 1, 1);
    end

`ifdef SEQ_TIMEOUT_EN
    clear_mon();
    no_comecou = 1'b1;
    pega_mode = 0;
    @(negedge clk);
    x_ini = 8'd1; x_fim = 8'd3; passo = 8'd1; A = 16'd1; B = 16'd1; C = 16'd1;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    wait_term(300, 1'b0, n);
    check_val("tmo_done", 64'(n < 300), 1);
    check_val("tmo_delay", term_cyc - first_opi, TMO);
    check_val("tmo_erro", erro, 1);
    repeat (5) @(negedge clk);
    #4;
    check_val("tmo_erro_sticky", erro, 1);
    check_val("tmo_term_once", term_cnt, 1);
    check_val("tmo_idle", {ocupado, op_inicio}, 0);
    no_comecou = 1'b0;
    run_sweep("after_tmo", 0, 2, 1, 1, 2, 5, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
